// File: rtl/mmio_bridge.sv
// Address decoder between the CPU data port and dmem, with the Tetris peripherals
// (key-event FIFO, gravity timer, score register) mapped into the top page.
module mmio_bridge #(
   parameter int          KEY_DEPTH     = 4,
   parameter logic [31:0] TIMER_DEFAULT = 32'd1000000,
   parameter logic [11:0] MMIO_BASE     = 12'hF00
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [11:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   input  logic        cpu_wren,
   input  logic        cpu_strobe,
   output logic [31:0] cpu_rdata,
   output logic [11:0] dmem_addr,
   output logic [31:0] dmem_data,
   output logic        dmem_wren,
   input  logic [31:0] dmem_q,
   input  logic        key_valid,
   input  logic [7:0]  key_code,
   output logic        tick,
   output logic [31:0] score
);
   localparam int PW = $clog2(KEY_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(KEY_DEPTH);

   localparam logic [11:0] OFF_KEY_STATUS   = 12'd0;
   localparam logic [11:0] OFF_KEY_DATA     = 12'd1;
   localparam logic [11:0] OFF_TIMER_PERIOD = 12'd2;
   localparam logic [11:0] OFF_TIMER_FLAG   = 12'd3;
   localparam logic [11:0] OFF_SCORE        = 12'd4;
   localparam logic [11:0] OFF_TIMER_COUNT  = 12'd5;

   logic [7:0]    key_mem [KEY_DEPTH];
   logic [PW-1:0] rd_ptr_reg, wr_ptr_reg;
   logic [CW-1:0] occ_reg;
   logic          ovf_reg;
   logic [31:0]   period_reg, count_reg, score_reg;
   logic          flag_reg, tick_reg;
   logic          region_reg;
   logic [31:0]   periph_rdata_reg, periph_rdata_next;

   logic        is_mmio;
   logic [11:0] offset;
   logic        rd_stb, wr_stb;
   logic        fifo_empty, fifo_full;
   logic        pop, push_ok, push_drop;
   logic        period_wr, expire;
   logic [4:0]  occ_ext;

   assign is_mmio    = (cpu_addr >= MMIO_BASE);
   assign offset     = cpu_addr - MMIO_BASE;
   assign rd_stb     = cpu_strobe & ~cpu_wren & is_mmio;
   assign wr_stb     = cpu_strobe & cpu_wren & is_mmio;
   assign fifo_empty = (occ_reg == '0);
   assign fifo_full  = (occ_reg == FULL_COUNT);
   assign pop        = rd_stb & (offset == OFF_KEY_DATA) & ~fifo_empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign push_ok    = key_valid & (~fifo_full | pop);
   assign push_drop  = key_valid & fifo_full & ~pop;
   assign period_wr  = wr_stb & (offset == OFF_TIMER_PERIOD);
   assign expire     = ~period_wr & (period_reg != '0) & (count_reg == period_reg - 32'd1);
   assign occ_ext    = 5'(occ_reg);

   assign dmem_addr = cpu_addr;
   assign dmem_data = cpu_wdata;
   assign dmem_wren = cpu_wren & cpu_strobe & ~is_mmio;
   assign cpu_rdata = region_reg ? periph_rdata_reg : dmem_q;
   assign tick      = tick_reg;
   assign score     = score_reg;

   always_comb begin
      periph_rdata_next = '0;
      case (offset)
         OFF_KEY_STATUS:   periph_rdata_next = {24'd0, ovf_reg, 2'b00, occ_ext[3:0], ~fifo_empty};
         OFF_KEY_DATA:     periph_rdata_next = fifo_empty ? 32'd0 : {24'd0, key_mem[rd_ptr_reg]};
         OFF_TIMER_PERIOD: periph_rdata_next = period_reg;
         OFF_TIMER_FLAG:   periph_rdata_next = {31'd0, flag_reg};
         OFF_SCORE:        periph_rdata_next = score_reg;
         OFF_TIMER_COUNT:  periph_rdata_next = count_reg;
         default:          periph_rdata_next = '0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (push_ok) begin
         key_mem[wr_ptr_reg] <= key_code;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rd_ptr_reg       <= '0;
         wr_ptr_reg       <= '0;
         occ_reg          <= '0;
         ovf_reg          <= 1'b0;
         region_reg       <= 1'b0;
         periph_rdata_reg <= '0;
      end else begin
         region_reg       <= is_mmio;
         periph_rdata_reg <= periph_rdata_next;
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (push_ok & ~pop) begin
            occ_reg <= occ_reg + 1'b1;
         end else if (pop & ~push_ok) begin
            occ_reg <= occ_reg - 1'b1;
         end
         // A drop in the same cycle as the status read keeps the new overflow visible.
         if (push_drop) begin
            ovf_reg <= 1'b1;
         end else if (rd_stb & (offset == OFF_KEY_STATUS)) begin
            ovf_reg <= 1'b0;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         period_reg <= TIMER_DEFAULT;
         count_reg  <= '0;
         flag_reg   <= 1'b0;
         tick_reg   <= 1'b0;
         score_reg  <= '0;
      end else begin
         if (period_wr) begin
            period_reg <= cpu_wdata;
            count_reg  <= '0;
            tick_reg   <= 1'b0;
         end else if (period_reg == '0) begin
            count_reg <= '0;
            tick_reg  <= 1'b0;
         end else if (expire) begin
            count_reg <= '0;
            tick_reg  <= 1'b1;
         end else begin
            count_reg <= count_reg + 32'd1;
            tick_reg  <= 1'b0;
         end
         if (expire) begin
            flag_reg <= 1'b1;
         end else if (wr_stb & (offset == OFF_TIMER_FLAG)) begin
            flag_reg <= 1'b0;
         end
         if (wr_stb & (offset == OFF_SCORE)) begin
            score_reg <= cpu_wdata;
         end
      end
   end
endmodule
